// File: rtl/prach_conv_sched.sv
// prach_conv_sched: per-channel FIFOs feeding one round-robin scheduled bus, with frame-sync flush.
module prach_conv_sched #(
    parameter int NUM_CHN    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [16*NUM_CHN-1:0]  din_dr,
    input  logic [16*NUM_CHN-1:0]  din_di,
    input  logic [NUM_CHN-1:0]     din_dv,
    input  logic                   sync_in,
    output logic [15:0]            dout_dr,
    output logic [15:0]            dout_di,
    output logic                   dout_dv,
    output logic [7:0]             dout_chn,
    output logic                   sync_out,
    output logic [NUM_CHN-1:0]     err_ovf
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CHW = NUM_CHN > 1 ? $clog2(NUM_CHN) : 1;

    logic [31:0]        mem_q [NUM_CHN][FIFO_DEPTH];
    logic [AW-1:0]      wp_q [NUM_CHN];
    logic [AW-1:0]      wp_d [NUM_CHN];
    logic [AW-1:0]      rp_q [NUM_CHN];
    logic [AW-1:0]      rp_d [NUM_CHN];
    logic [CW-1:0]      cnt_q [NUM_CHN];
    logic [CW-1:0]      cnt_d [NUM_CHN];
    logic [NUM_CHN-1:0] ne, pop, acc, ovf_q, ovf_d;
    logic [CHW-1:0]     ptr_q, ptr_d, gnt;
    logic [CHW:0]       k;
    logic               gnt_v;
    logic [15:0]        dr_q, di_q;
    logic [7:0]         chn_q;
    logic               dv_q, sync_q;

    // Scan from the highest offset down so the nearest candidate after ptr is the last one written.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        k     = '0;
        for (int c = 0; c < NUM_CHN; c++) ne[c] = cnt_q[c] != CW'(0);
        for (int i = NUM_CHN; i >= 1; i--) begin
            k = {1'b0, ptr_q} + (CHW+1)'(i);
            k = k >= (CHW+1)'(NUM_CHN) ? k - (CHW+1)'(NUM_CHN) : k;
            if (ne[k[CHW-1:0]]) begin
                gnt_v = 1'b1;
                gnt   = k[CHW-1:0];
            end
        end
        gnt_v = gnt_v & ~sync_in;
        ptr_d = sync_in ? CHW'(NUM_CHN-1) : gnt_v ? gnt : ptr_q;
    end

    // Sync flushes by snapping rd to wr; a same-cycle write then lands as the new frame's first entry.
    always_comb begin
        for (int c = 0; c < NUM_CHN; c++) begin
            pop[c]   = gnt_v && gnt == CHW'(c);
            acc[c]   = din_dv[c] && (sync_in || pop[c] || cnt_q[c] != CW'(FIFO_DEPTH));
            cnt_d[c] = (sync_in ? CW'(0) : cnt_q[c] - CW'(pop[c])) + CW'(acc[c]);
            rp_d[c]  = sync_in ? wp_q[c] : rp_q[c] + AW'(pop[c]);
            wp_d[c]  = wp_q[c] + AW'(acc[c]);
            ovf_d[c] = ovf_q[c] | (din_dv[c] & ~acc[c]);
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHN; c++)
            if (acc[c]) mem_q[c][wp_q[c]] <= {din_di[16*c +: 16], din_dr[16*c +: 16]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                cnt_q[c] <= '0;
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
            end
            ptr_q  <= CHW'(NUM_CHN-1);
            ovf_q  <= '0;
            dr_q   <= '0;
            di_q   <= '0;
            chn_q  <= '0;
            dv_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHN; c++) begin
                cnt_q[c] <= cnt_d[c];
                wp_q[c]  <= wp_d[c];
                rp_q[c]  <= rp_d[c];
            end
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
            dv_q   <= gnt_v;
            sync_q <= sync_in;
            if (gnt_v) begin
                {di_q, dr_q} <= mem_q[gnt][rp_q[gnt]];
                chn_q        <= 8'(gnt);
            end
        end
    end

    assign dout_dr  = dr_q;
    assign dout_di  = di_q;
    assign dout_dv  = dv_q;
    assign dout_chn = chn_q;
    assign sync_out = sync_q;
    assign err_ovf  = ovf_q;
endmodule

// File: tb/tb_prach_conv_sched.sv
// tb_prach_conv_sched: random and directed stimulus checked against a queue-based round-robin model.
module tb_prach_conv_sched;
    localparam int N = 4;
    localparam int D = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [16*N-1:0] din_dr, din_di;
    logic [N-1:0]    din_dv;
    logic            sync_in;
    logic [15:0]     dout_dr, dout_di;
    logic            dout_dv;
    logic [7:0]      dout_chn;
    logic            sync_out;
    logic [N-1:0]    err_ovf;

    logic [31:0] q [N][$];
    int          ptr;
    logic        e_dv, e_sy;
    logic [15:0] e_dr, e_di;
    logic [7:0]  e_chn;
    logic [N-1:0] e_ovf;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    prach_conv_sched #(.NUM_CHN(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .sync_out(sync_out), .err_ovf(err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of behaviour: serve the next non-empty channel after ptr, then flush/accept writes.
    task automatic model();
        int g;
        logic [31:0] d;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) q[c].delete();
            ptr = N - 1;
            {e_dv, e_sy, e_dr, e_di, e_chn, e_ovf} = '0;
        end else begin
            e_sy = sync_in;
            e_dv = 1'b0;
            g = -1;
            if (!sync_in)
                for (int i = 1; i <= N; i++)
                    if (g < 0 && q[(ptr + i) % N].size() > 0) g = (ptr + i) % N;
            if (g >= 0) begin
                d     = q[g].pop_front();
                e_dv  = 1'b1;
                e_dr  = d[15:0];
                e_di  = d[31:16];
                e_chn = 8'(g);
                ptr   = g;
            end
            if (sync_in) begin
                for (int c = 0; c < N; c++) q[c].delete();
                ptr = N - 1;
            end
            for (int c = 0; c < N; c++)
                if (din_dv[c]) begin
                    if (q[c].size() < D) q[c].push_back({din_di[16*c +: 16], din_dr[16*c +: 16]});
                    else e_ovf[c] = 1'b1;
                end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        chk("dout_dv", 32'(dout_dv), 32'(e_dv));
        chk("sync_out", 32'(sync_out), 32'(e_sy));
        chk("err_ovf", 32'(err_ovf), 32'(e_ovf));
        chk("dout_chn", 32'(dout_chn), 32'(e_chn));
        chk("dout_dr", 32'(dout_dr), 32'(e_dr));
        chk("dout_di", 32'(dout_di), 32'(e_di));
    endtask

    task automatic step(input logic [N-1:0] dv, input logic sy);
        din_dv  = dv;
        sync_in = sy;
        for (int c = 0; c < N; c++) begin
            din_dr[16*c +: 16] = 16'($urandom);
            din_di[16*c +: 16] = 16'($urandom);
        end
        cyc();
    endtask

    initial begin
        logic [N-1:0] dv;
        rst_n   = 1'b0;
        din_dv  = '1;
        sync_in = 1'b0;
        din_dr  = '0;
        din_di  = '0;
        repeat (5) step('1, 1'b0);
        rst_n = 1'b1;
        step('1, 1'b0);
        repeat (6) step('0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            din_dv = 4'b0100;
            din_dr[47:32] = 16'(i);
            din_di[47:32] = ~16'(i);
            cyc();
        end
        repeat (3) step('0, 1'b0);
        repeat (10) begin
            step('1, 1'b0);
            repeat (3) step('0, 1'b0);
        end
        repeat (12) step('1, 1'b0);
        repeat (10) step('0, 1'b0);
        repeat (2) step(4'b1001, 1'b0);
        step(4'b1000, 1'b1);
        repeat (4) step('0, 1'b0);
        repeat (3) step('1, 1'b0);
        rst_n = 1'b0;
        step('1, 1'b0);
        rst_n = 1'b1;
        repeat (3) step('1, 1'b0);
        repeat (10) step('0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom % 300) != 0;
            for (int c = 0; c < N; c++) dv[c] = ($urandom % 3) == 0;
            step(dv, ($urandom % 40) == 0);
        end
        rst_n = 1'b1;
        repeat (10) step('0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
